// File: rtl/dec_scan_low.sv
// rtl/dec_scan_low.sv - registered active-low one-hot decoder with auto-scan sequencer
module dec_scan_low #(
   parameter int N     = 4,
   parameter int DWELL = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                en,
   input  logic                mode,
   input  logic [N-1:0]        w,
   input  logic                load,
   output logic [(1<<N)-1:0]   y,
   output logic [N-1:0]        idx,
   output logic                wrap
);

   localparam int M  = 1 << N;
   localparam int DW = (DWELL > 1) ? $clog2(DWELL) : 1;
   localparam logic [DW-1:0] LAST  = DW'(DWELL - 1);
   localparam logic [N-1:0]  TOP   = {N{1'b1}};
   localparam logic [M-1:0]  ONE_M = {{(M-1){1'b0}}, 1'b1};

   logic [N-1:0]  r_idx;
   logic [DW-1:0] r_dcnt;
   logic [M-1:0]  r_y;
   logic          r_wrap;

   logic [N-1:0]  w_idx_nxt;
   logic [DW-1:0] w_dcnt_nxt;
   logic          w_wrap_nxt;
   logic [M-1:0]  w_y_nxt;

   // Next index/dwell/wrap: blank holds state, direct follows w, scan steps with load taking priority
   always_comb begin
      w_idx_nxt  = r_idx;
      w_dcnt_nxt = r_dcnt;
      w_wrap_nxt = 1'b0;
      if (en) begin
         if (!mode) begin
            w_idx_nxt  = w;
            w_dcnt_nxt = '0;
         end else if (load) begin
            w_idx_nxt  = w;
            w_dcnt_nxt = '0;
         end else if (r_dcnt == LAST) begin
            w_dcnt_nxt = '0;
            w_idx_nxt  = r_idx + 1'b1;
            w_wrap_nxt = (r_idx == TOP);
         end else begin
            w_dcnt_nxt = r_dcnt + 1'b1;
         end
      end
   end

   // Select lines are decoded from the next index so y and idx always change together
   always_comb begin
      w_y_nxt = '1;
      if (en) begin
         w_y_nxt = ~(ONE_M << w_idx_nxt);
      end
   end

   // All outputs come straight from flops so the strobes are glitch-free
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_idx  <= '0;
         r_dcnt <= '0;
         r_y    <= '1;
         r_wrap <= 1'b0;
      end else begin
         r_idx  <= w_idx_nxt;
         r_dcnt <= w_dcnt_nxt;
         r_y    <= w_y_nxt;
         r_wrap <= w_wrap_nxt;
      end
   end

   assign y    = r_y;
   assign idx  = r_idx;
   assign wrap = r_wrap;

endmodule
